// File: rtl/vic_config_regs_v2_pkg.sv
// Shared defaults and encodings for the VIC configuration register bank.
package vic_config_regs_v2_pkg;

  localparam int DEF_CONFREG_WIDTH     = 4;
  localparam int DEF_ARRAY_LENGTH      = 32;
  localparam int DEF_CONFREGADDR_WIDTH = 5;

  // Read-source select encodings
  localparam logic RSEL_STAGING = 1'b0;
  localparam logic RSEL_ACTIVE  = 1'b1;

endpackage

// File: rtl/vic_config_regs_v2_if.sv
// Software-facing bus of the VIC configuration register bank.
interface vic_config_regs_v2_if
  import vic_config_regs_v2_pkg::*;
#(
  parameter int CONFREG_WIDTH     = DEF_CONFREG_WIDTH,
  parameter int CONFREGADDR_WIDTH = DEF_CONFREGADDR_WIDTH
) ();

  logic [CONFREGADDR_WIDTH-1:0] i_VIC_regaddr;
  logic [CONFREG_WIDTH-1:0]     i_VIC_data;
  logic                         i_VIC_we;
  logic                         i_VIC_re;
  logic                         i_VIC_rsel;
  logic [CONFREG_WIDTH-1:0]     o_VIC_data;
  logic                         o_VIC_rvalid;
  logic                         i_VIC_commit;
  logic                         o_VIC_update;
  logic                         o_VIC_pending;
  logic                         i_VIC_lock;
  logic                         o_VIC_locked;
  logic                         o_VIC_err;
  logic                         i_VIC_err_clr;

  modport master (
    output i_VIC_regaddr, i_VIC_data, i_VIC_we, i_VIC_re, i_VIC_rsel,
           i_VIC_commit, i_VIC_lock, i_VIC_err_clr,
    input  o_VIC_data, o_VIC_rvalid, o_VIC_update, o_VIC_pending,
           o_VIC_locked, o_VIC_err
  );

  modport slave (
    input  i_VIC_regaddr, i_VIC_data, i_VIC_we, i_VIC_re, i_VIC_rsel,
           i_VIC_commit, i_VIC_lock, i_VIC_err_clr,
    output o_VIC_data, o_VIC_rvalid, o_VIC_update, o_VIC_pending,
           o_VIC_locked, o_VIC_err
  );

endinterface

// File: rtl/vic_config_regs_v2_reg_slot.sv
// One configuration entry: staging copy, active copy and dirty bit.
module vic_reg_slot
  import vic_config_regs_v2_pkg::*;
#(
  parameter int                         CONFREG_WIDTH = DEF_CONFREG_WIDTH,
  parameter logic [CONFREG_WIDTH-1:0]   RESET_VALUE   = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic                     commit,
  input  logic [CONFREG_WIDTH-1:0] data,
  output logic [CONFREG_WIDTH-1:0] staging,
  output logic [CONFREG_WIDTH-1:0] active,
  output logic                     dirty
);

  // Active value after this edge; a write racing a commit is compared against it
  logic [CONFREG_WIDTH-1:0] next_active;
  assign next_active = commit ? staging : active;

  // Commit copies the pre-write staging value; a write then re-evaluates dirty
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      staging <= RESET_VALUE;
      active  <= RESET_VALUE;
      dirty   <= 1'b0;
    end else begin
      if (commit) active <= staging;
      if (we) begin
        staging <= data;
        dirty   <= (data != next_active);
      end else if (commit) begin
        dirty   <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/vic_config_regs_v2.sv
// Double-buffered VIC configuration bank: decode, read port, lock, error, update pulse.
module vic_config_regs_v2
  import vic_config_regs_v2_pkg::*;
#(
  parameter int                       CONFREG_WIDTH     = DEF_CONFREG_WIDTH,
  parameter int                       ARRAY_LENGTH      = DEF_ARRAY_LENGTH,
  parameter int                       CONFREGADDR_WIDTH = DEF_CONFREGADDR_WIDTH,
  parameter logic [CONFREG_WIDTH-1:0] RESET_VALUE       = '0
) (
  input  logic                                  clk,
  input  logic                                  rst,
  vic_config_regs_v2_if.slave                   bus,
  output logic [CONFREG_WIDTH*ARRAY_LENGTH-1:0] o_buffer
);

  localparam logic [CONFREGADDR_WIDTH:0] LEN = (CONFREGADDR_WIDTH+1)'(ARRAY_LENGTH);

  logic [CONFREG_WIDTH-1:0] staging_arr [ARRAY_LENGTH];
  logic [CONFREG_WIDTH-1:0] active_arr  [ARRAY_LENGTH];
  logic [ARRAY_LENGTH-1:0]  dirty;
  logic [ARRAY_LENGTH-1:0]  slot_we;

  logic                     locked;
  logic                     err;
  logic                     addr_ok;
  logic                     wr_ok;
  logic                     commit_ok;
  logic                     err_set;
  logic [CONFREG_WIDTH-1:0] rd_sel_p0;
  logic [CONFREG_WIDTH-1:0] rd_data_p1;
  logic                     vld_p1;
  logic                     update_p1;

  assign addr_ok   = ({1'b0, bus.i_VIC_regaddr} < LEN);
  assign wr_ok     = bus.i_VIC_we & addr_ok & ~locked;
  assign commit_ok = bus.i_VIC_commit & ~locked;
  assign err_set   = (bus.i_VIC_we & (~addr_ok | locked))
                   | (bus.i_VIC_commit & locked)
                   | (bus.i_VIC_re & ~addr_ok);

  for (genvar i = 0; i < ARRAY_LENGTH; i++) begin : g_slot
    assign slot_we[i] = wr_ok & (bus.i_VIC_regaddr == CONFREGADDR_WIDTH'(i));

    vic_reg_slot #(
      .CONFREG_WIDTH (CONFREG_WIDTH),
      .RESET_VALUE   (RESET_VALUE)
    ) u_slot (
      .clk     (clk),
      .rst     (rst),
      .we      (slot_we[i]),
      .commit  (commit_ok),
      .data    (bus.i_VIC_data),
      .staging (staging_arr[i]),
      .active  (active_arr[i]),
      .dirty   (dirty[i])
    );

    assign o_buffer[CONFREG_WIDTH*i +: CONFREG_WIDTH] = active_arr[i];
  end

  // Stage p0: select the addressed entry from the requested array
  always_comb begin
    rd_sel_p0 = '0;
    if (addr_ok) begin
      rd_sel_p0 = (bus.i_VIC_rsel == RSEL_ACTIVE) ? active_arr[bus.i_VIC_regaddr]
                                                  : staging_arr[bus.i_VIC_regaddr];
    end
  end

  // Stage p1: registered read data (held between reads) and its valid pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data_p1 <= '0;
      vld_p1     <= 1'b0;
    end else begin
      vld_p1 <= bus.i_VIC_re;
      if (bus.i_VIC_re) rd_data_p1 <= rd_sel_p0;
    end
  end

  // Update pulse only when an accepted commit actually moves dirty entries
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) update_p1 <= 1'b0;
    else      update_p1 <= commit_ok & (|dirty);
  end

  // Lock is one-way; error set takes priority over clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      locked <= 1'b0;
      err    <= 1'b0;
    end else begin
      if (bus.i_VIC_lock) locked <= 1'b1;
      if (err_set)                 err <= 1'b1;
      else if (bus.i_VIC_err_clr)  err <= 1'b0;
    end
  end

  assign bus.o_VIC_data    = rd_data_p1;
  assign bus.o_VIC_rvalid  = vld_p1;
  assign bus.o_VIC_update  = update_p1;
  assign bus.o_VIC_pending = |dirty;
  assign bus.o_VIC_locked  = locked;
  assign bus.o_VIC_err     = err;

endmodule

// File: tb/tb_vic_config_regs_v2.sv
// Directed bench for vic_config_regs_v2 (32-entry and 20-entry builds).
module tb_vic_config_regs_v2;

  logic clk;
  logic rst;
  logic [127:0] buf32;
  logic [79:0]  buf20;
  logic [127:0] exp_buf;
  int checks;
  int fails;

  vic_config_regs_v2_if #(.CONFREG_WIDTH(4), .CONFREGADDR_WIDTH(5)) bus ();
  vic_config_regs_v2_if #(.CONFREG_WIDTH(4), .CONFREGADDR_WIDTH(5)) bus20 ();

  vic_config_regs_v2 #(
    .CONFREG_WIDTH(4), .ARRAY_LENGTH(32), .CONFREGADDR_WIDTH(5), .RESET_VALUE(4'h0)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .o_buffer(buf32)
  );

  vic_config_regs_v2 #(
    .CONFREG_WIDTH(4), .ARRAY_LENGTH(20), .CONFREGADDR_WIDTH(5), .RESET_VALUE(4'h0)
  ) dut20 (
    .clk(clk), .rst(rst), .bus(bus20), .o_buffer(buf20)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.i_VIC_regaddr = '0;   bus.i_VIC_data = '0;    bus.i_VIC_we = 1'b0;
    bus.i_VIC_re = 1'b0;      bus.i_VIC_rsel = 1'b0;  bus.i_VIC_commit = 1'b0;
    bus.i_VIC_lock = 1'b0;    bus.i_VIC_err_clr = 1'b0;
    bus20.i_VIC_regaddr = '0; bus20.i_VIC_data = '0;  bus20.i_VIC_we = 1'b0;
    bus20.i_VIC_re = 1'b0;    bus20.i_VIC_rsel = 1'b0; bus20.i_VIC_commit = 1'b0;
    bus20.i_VIC_lock = 1'b0;  bus20.i_VIC_err_clr = 1'b0;
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    exp_buf = '0;
    rst = 1'b0;
    idle();
    #2;
    chk("rst_rvalid",  128'(bus.o_VIC_rvalid), 128'(1'b0));
    chk("rst_data",    128'(bus.o_VIC_data), 128'(4'h0));
    chk("rst_update",  128'(bus.o_VIC_update), 128'(1'b0));
    chk("rst_pending", 128'(bus.o_VIC_pending), 128'(1'b0));
    chk("rst_locked",  128'(bus.o_VIC_locked), 128'(1'b0));
    chk("rst_err",     128'(bus.o_VIC_err), 128'(1'b0));
    chk("rst_buffer",  buf32, 128'(0));
    #10;
    rst = 1'b1;

    // 1: read every active entry after reset
    for (int i = 0; i < 32; i++) begin
      bus.i_VIC_re = 1'b1; bus.i_VIC_rsel = 1'b1; bus.i_VIC_regaddr = 5'(i);
      tick();
      chk($sformatf("rd_act_vld_%0d", i), 128'(bus.o_VIC_rvalid), 128'(1'b1));
      chk($sformatf("rd_act_dat_%0d", i), 128'(bus.o_VIC_data), 128'(4'h0));
    end
    idle();
    tick();
    chk("rvalid_pulse_end", 128'(bus.o_VIC_rvalid), 128'(1'b0));
    chk("t1_pending", 128'(bus.o_VIC_pending), 128'(1'b0));

    // 2: two writes then commit
    bus.i_VIC_we = 1'b1; bus.i_VIC_regaddr = 5'd3; bus.i_VIC_data = 4'hA;
    tick();
    bus.i_VIC_regaddr = 5'd31; bus.i_VIC_data = 4'h5;
    tick();
    idle();
    chk("t2_pending", 128'(bus.o_VIC_pending), 128'(1'b1));
    chk("t2_buf_before", buf32, 128'(0));
    bus.i_VIC_commit = 1'b1;
    tick();
    idle();
    exp_buf[15:12] = 4'hA;
    exp_buf[127:124] = 4'h5;
    chk("t2_update", 128'(bus.o_VIC_update), 128'(1'b1));
    chk("t2_buf_after", buf32, exp_buf);
    chk("t2_pending_clr", 128'(bus.o_VIC_pending), 128'(1'b0));
    tick();
    chk("t2_update_pulse", 128'(bus.o_VIC_update), 128'(1'b0));

    // 3: write then restore the active value; commit gives no pulse
    bus.i_VIC_we = 1'b1; bus.i_VIC_regaddr = 5'd7; bus.i_VIC_data = 4'h9;
    tick();
    chk("t3_pending_set", 128'(bus.o_VIC_pending), 128'(1'b1));
    bus.i_VIC_data = 4'h0;
    tick();
    idle();
    chk("t3_pending_clr", 128'(bus.o_VIC_pending), 128'(1'b0));
    bus.i_VIC_commit = 1'b1;
    tick();
    idle();
    chk("t3_no_update", 128'(bus.o_VIC_update), 128'(1'b0));
    chk("t3_buf", buf32, exp_buf);
    chk("t3_err", 128'(bus.o_VIC_err), 128'(1'b0));

    // 4: simultaneous write and read of the same staging entry
    bus.i_VIC_we = 1'b1; bus.i_VIC_re = 1'b1; bus.i_VIC_rsel = 1'b0;
    bus.i_VIC_regaddr = 5'd2; bus.i_VIC_data = 4'h6;
    tick();
    idle();
    chk("t4_rvalid", 128'(bus.o_VIC_rvalid), 128'(1'b1));
    chk("t4_old_data", 128'(bus.o_VIC_data), 128'(4'h0));
    bus.i_VIC_re = 1'b1; bus.i_VIC_rsel = 1'b0; bus.i_VIC_regaddr = 5'd2;
    tick();
    idle();
    chk("t4_new_data", 128'(bus.o_VIC_data), 128'(4'h6));
    tick();
    chk("t4_hold_data", 128'(bus.o_VIC_data), 128'(4'h6));
    chk("t4_hold_vld", 128'(bus.o_VIC_rvalid), 128'(1'b0));

    // commit racing a write: commit takes pre-write staging, written entry stays dirty
    bus.i_VIC_commit = 1'b1; bus.i_VIC_we = 1'b1;
    bus.i_VIC_regaddr = 5'd5; bus.i_VIC_data = 4'h3;
    tick();
    idle();
    exp_buf[11:8] = 4'h6;
    chk("cw_update", 128'(bus.o_VIC_update), 128'(1'b1));
    chk("cw_buf", buf32, exp_buf);
    chk("cw_pending", 128'(bus.o_VIC_pending), 128'(1'b1));
    bus.i_VIC_commit = 1'b1;
    tick();
    idle();
    exp_buf[23:20] = 4'h3;
    chk("cw2_buf", buf32, exp_buf);
    chk("cw2_pending", 128'(bus.o_VIC_pending), 128'(1'b0));

    // 5: out-of-range access on the 20-entry build
    bus20.i_VIC_we = 1'b1; bus20.i_VIC_regaddr = 5'd25; bus20.i_VIC_data = 4'hF;
    tick();
    idle();
    chk("t5_err_set", 128'(bus20.o_VIC_err), 128'(1'b1));
    chk("t5_pending", 128'(bus20.o_VIC_pending), 128'(1'b0));
    chk("t5_buf", 128'(buf20), 128'(0));
    bus20.i_VIC_err_clr = 1'b1;
    tick();
    idle();
    chk("t5_err_clr", 128'(bus20.o_VIC_err), 128'(1'b0));
    bus20.i_VIC_err_clr = 1'b1; bus20.i_VIC_re = 1'b1;
    bus20.i_VIC_rsel = 1'b1; bus20.i_VIC_regaddr = 5'd22;
    tick();
    idle();
    chk("t5_err_wins", 128'(bus20.o_VIC_err), 128'(1'b1));
    chk("t5_oor_vld", 128'(bus20.o_VIC_rvalid), 128'(1'b1));
    chk("t5_oor_data", 128'(bus20.o_VIC_data), 128'(4'h0));
    chk("t5_main_err", 128'(bus.o_VIC_err), 128'(1'b0));

    // 6: lock blocks writes and commits, reads still work
    bus.i_VIC_lock = 1'b1;
    tick();
    idle();
    chk("t6_locked", 128'(bus.o_VIC_locked), 128'(1'b1));
    chk("t6_err_lock", 128'(bus.o_VIC_err), 128'(1'b0));
    bus.i_VIC_we = 1'b1; bus.i_VIC_regaddr = 5'd1; bus.i_VIC_data = 4'hF;
    tick();
    idle();
    chk("t6_err_wr", 128'(bus.o_VIC_err), 128'(1'b1));
    chk("t6_pending", 128'(bus.o_VIC_pending), 128'(1'b0));
    bus.i_VIC_commit = 1'b1;
    tick();
    idle();
    chk("t6_no_update", 128'(bus.o_VIC_update), 128'(1'b0));
    chk("t6_buf", buf32, exp_buf);
    bus.i_VIC_re = 1'b1; bus.i_VIC_rsel = 1'b0; bus.i_VIC_regaddr = 5'd1;
    tick();
    chk("t6_rd_stg", 128'(bus.o_VIC_data), 128'(4'h0));
    bus.i_VIC_rsel = 1'b1; bus.i_VIC_regaddr = 5'd3;
    tick();
    idle();
    chk("t6_rd_vld", 128'(bus.o_VIC_rvalid), 128'(1'b1));
    chk("t6_rd_act", 128'(bus.o_VIC_data), 128'(4'hA));

    // asynchronous reset in the middle of a cycle
    #3;
    rst = 1'b0;
    #1;
    chk("ar_rvalid", 128'(bus.o_VIC_rvalid), 128'(1'b0));
    chk("ar_data", 128'(bus.o_VIC_data), 128'(4'h0));
    chk("ar_locked", 128'(bus.o_VIC_locked), 128'(1'b0));
    chk("ar_err", 128'(bus.o_VIC_err), 128'(1'b0));
    chk("ar_update", 128'(bus.o_VIC_update), 128'(1'b0));
    chk("ar_buf", buf32, 128'(0));
    chk("ar_err20", 128'(bus20.o_VIC_err), 128'(1'b0));
    #3;
    rst = 1'b1;
    tick();
    chk("post_rst_vld", 128'(bus.o_VIC_rvalid), 128'(1'b0));
    chk("post_rst_locked", 128'(bus.o_VIC_locked), 128'(1'b0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
